// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: op codes and FSM encoding.
package alu_pkg;

  localparam int SEL_W = 4;

  localparam logic [SEL_W-1:0] OP_AND = 4'd0;
  localparam logic [SEL_W-1:0] OP_OR  = 4'd1;
  localparam logic [SEL_W-1:0] OP_XOR = 4'd2;
  localparam logic [SEL_W-1:0] OP_ADD = 4'd3;
  localparam logic [SEL_W-1:0] OP_SUB = 4'd4;
  localparam logic [SEL_W-1:0] OP_SLL = 4'd5;
  localparam logic [SEL_W-1:0] OP_SRL = 4'd6;
  localparam logic [SEL_W-1:0] OP_SLT = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the client blocks and the shared ALU scheduler.
interface alu_rr_scheduler_if
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int SEL_W   = alu_pkg::SEL_W
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0]      req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0]      req_b;
  logic [NUM_REQ-1:0][SEL_W-1:0]      req_sel;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [NUM_REQ-1:0]                 rsp_ready;
  logic [WIDTH-1:0]                   rsp_data;
  logic                               rsp_err;

  // Client side: issues operations and accepts results.
  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/alu32_core.sv
// Purely combinational ALU: AND/OR/XOR/ADD/SUB/SLL/SRL/SLT, flags unused op codes.
module alu32_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  // Op decode; illegal selects produce a zero result with the flag set.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (sel)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_SLL: result = a << b[4:0];
      OP_SRL: result = a >> b[4:0];
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between NUM_REQ requesters; round-robin grant, one op in flight.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int SEL_W   = alu_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  alu_rr_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SEL_W-1:0] sel;
  } op_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   last_grant, gnt_q, gnt_idx, cand;
  logic               gnt_found, accept;
  int                 rr_j;
  op_t                op_q;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ill;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_err_q;

  // Round-robin search: first valid starting just after the last grant, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_j      = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_j = int'(last_grant) + k;
      if (rr_j >= NUM_REQ) rr_j = rr_j - NUM_REQ;
      cand = IDX_W'(rr_j);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Never advertise an accept while reset is discarding the would-be transfer.
  assign accept = (state == IDLE) && gnt_found && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept -> one EXEC cycle -> hold RESP until owner takes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready[gnt_q]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: accept strobe to the granted requester only.
  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt_idx] = 1'b1;
  end

  alu32_core #(.WIDTH(WIDTH)) u_alu (
    .a       (op_q.a),
    .b       (op_q.b),
    .sel     (op_q.sel),
    .result  (alu_res),
    .illegal (alu_ill)
  );

  // Datapath: latch operands on accept, register ALU result in EXEC, retire in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= IDX_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      op_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q.a     <= bus.req_a[gnt_idx];
            op_q.b     <= bus.req_b[gnt_idx];
            op_q.sel   <= bus.req_sel[gnt_idx];
            gnt_q      <= gnt_idx;
            last_grant <= gnt_idx;
          end
        end
        EXEC: begin
          rsp_data_q         <= alu_res;
          rsp_err_q          <= alu_ill;
          rsp_valid_q        <= '0;
          rsp_valid_q[gnt_q] <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready[gnt_q]) rsp_valid_q <= '0;
        end
        default: rsp_valid_q <= '0;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
